id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding network for the five-stage MIPS core.
- Latches decoded instruction fields each cycle and resolves operand hazards.
- Drives BussA, BussB and ALUControl of the downstream alu: 00 add, 01 xor, 10 sub, 11 slt.
- Detects load-use hazards and requests a one-cycle stall from IF/ID.

Parameters:
- WIDTH, 32, datapath width.
- REG_BITS, 5, register-specifier width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  REG_BITS  source/dest specifiers from decode.
- id_data_a, id_data_b  in  WIDTH  register-file read data.
- id_imm  in  WIDTH  sign-extended immediate.
- id_alu_src  in  1  1 = operand B is the immediate.
- id_reg_dst  in  1  1 = destination is rd, else rt.
- id_alu_ctrl  in  2  ALU operation.
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits.
- flush  in  1  branch-taken squash of the ID instruction.
- exmem_reg_write  in  1  EX/MEM writes a register.
- exmem_rd  in  REG_BITS  EX/MEM destination.
- exmem_result  in  WIDTH  EX/MEM ALU result.
- memwb_reg_write  in  1  MEM/WB writes a register.
- memwb_rd  in  REG_BITS  MEM/WB destination.
- memwb_data  in  WIDTH  MEM/WB writeback data.
- BussA, BussB  out  WIDTH  ALU operands.
- ALUControl  out  2  ALU operation.
- ex_store_data  out  WIDTH  forwarded rt value for stores.
- ex_dest  out  REG_BITS  destination register.
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control.
- stall_req  out  1  hold PC and IF/ID this cycle.

Behaviour:
- Reset (async, reset_n=0): all registered fields are cleared to 0, so ex_valid=0, all control bits 0, ALUControl=00 and ex_dest=0. BussA/BussB/ex_store_data then equal the forwarded zero data.
- Load-use stall (combinational): stall_req = ex_valid & ex_mem_read & (ex_dest!=0) & id_valid & (ex_dest==id_rs | ex_dest==id_rt).
- Each rising edge, one of three actions:
  - Bubble, when flush | stall_req | !id_valid: ex_valid and all write/mem control bits go to 0. Data fields may load but are don't-care.
  - Otherwise: load all ID fields. ex_dest = id_reg_dst ? id_rd : id_rt. ex_valid=1.
  - flush and stall_req together: bubble, and stall_req still asserts.
- Forwarding (combinational, from the registered rs/rt):
  - fwdA = exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs_q.
  - Otherwise memwb_data if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs_q.
  - Otherwise data_a_q.
  - fwdB uses the same priority on rt_q / data_b_q.
  - EX/MEM always beats MEM/WB. Register 0 is never forwarded.
- Outputs: BussA = fwdA. BussB = alu_src_q ? imm_q : fwdB. ex_store_data = fwdB, independent of alu_src. ALUControl = alu_ctrl_q.
- Latency: one cycle from ID to the ALU operands; forwarding adds zero cycles.
- Reset mid-stall: stall_req deasserts within the same cycle because ex_valid clears.

Decomposition:
- Package mips_pipe_pkg holds:
  - the alu_op_t enum: ALU_ADD=2'b00, ALU_XOR=2'b01, ALU_SUB=2'b10, ALU_SLT=2'b11;
  - a ctrl_t struct {reg_write, mem_read, mem_write, mem_to_reg};
  - REG_ZERO=5'd0.
- One sub-module, fwd_mux, instantiated twice for A and B. Inputs: src reg, queue data, the two writer ports. Output: forwarded data.

Test Plan:
- Plain add, no hazards: data_a=0DEF, data_b=0ABC, ctrl=00. After 1 clk, BussA=00000DEF, BussB=00000ABC, ALUControl=00, ex_valid=1.
- EX/MEM forward: rs_q=3, exmem_reg_write=1, exmem_rd=3, exmem_result=7FFFFFFF, data_a_q=0 -> BussA=7FFFFFFF.
- Both stages match rt=5, exmem_result=00001234, memwb_data=00000105 -> BussB=00001234. With memwb only -> BussB=00000105. Writer rd=0 -> no forwarding.
- Load-use: EX holds lw with ex_dest=8; ID has rs=8 -> stall_req=1. Next edge, ex_valid=0 and ex_reg_write=0. Following cycle stall_req=0.
- alu_src=1, imm=FFFFFFFF, rt forwarded 0000AAAA -> BussB=FFFFFFFF, ex_store_data=0000AAAA.
- flush together with a valid instruction -> bubble. reset_n dropped mid-cycle -> all control outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types for the five-stage MIPS pipeline: ALU opcodes, EX control
// bundle and the hard-wired zero register specifier.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_XOR = 2'b01,
    ALU_SUB = 2'b10,
    ALU_SLT = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam ctrl_t      CTRL_NONE = '0;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight producer of i_src,
// falling back to the value latched from the register file. Register 0 is
// never forwarded because it reads as zero architecturally.
module fwd_mux
  import mips_pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] i_src,
  input  logic [WIDTH-1:0]    i_data_q,
  input  logic                i_exmem_reg_write,
  input  logic [REG_BITS-1:0] i_exmem_rd,
  input  logic [WIDTH-1:0]    i_exmem_result,
  input  logic                i_memwb_reg_write,
  input  logic [REG_BITS-1:0] i_memwb_rd,
  input  logic [WIDTH-1:0]    i_memwb_data,
  output logic [WIDTH-1:0]    o_data
);

  localparam logic [REG_BITS-1:0] ZERO_REG = REG_BITS'(REG_ZERO);

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = i_exmem_reg_write && (i_exmem_rd != ZERO_REG) && (i_exmem_rd == i_src);
  assign w_memwb_hit = i_memwb_reg_write && (i_memwb_rd != ZERO_REG) && (i_memwb_rd == i_src);

  // EX/MEM is younger than MEM/WB, so it takes priority on a double match.
  assign o_data = w_exmem_hit ? i_exmem_result :
                  w_memwb_hit ? i_memwb_data   : i_data_q;

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding into the ALU and
// load-use hazard detection that stalls IF/ID for one cycle.
module id_ex_operand_stage
  import mips_pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic [WIDTH-1:0]    id_data_a,
  input  logic [WIDTH-1:0]    id_data_b,
  input  logic [WIDTH-1:0]    id_imm,
  input  logic                id_alu_src,
  input  logic                id_reg_dst,
  input  logic [1:0]          id_alu_ctrl,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                flush,
  input  logic                exmem_reg_write,
  input  logic [REG_BITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]    exmem_result,
  input  logic                memwb_reg_write,
  input  logic [REG_BITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]    memwb_data,
  output logic [WIDTH-1:0]    BussA,
  output logic [WIDTH-1:0]    BussB,
  output logic [1:0]          ALUControl,
  output logic [WIDTH-1:0]    ex_store_data,
  output logic [REG_BITS-1:0] ex_dest,
  output logic                ex_valid,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                stall_req
);

  localparam logic [REG_BITS-1:0] ZERO_REG = REG_BITS'(REG_ZERO);

  logic                r_valid;
  ctrl_t               r_ctrl;
  alu_op_t             r_alu_ctrl;
  logic                r_alu_src;
  logic [REG_BITS-1:0] r_rs;
  logic [REG_BITS-1:0] r_rt;
  logic [REG_BITS-1:0] r_dest;
  logic [WIDTH-1:0]    r_data_a;
  logic [WIDTH-1:0]    r_data_b;
  logic [WIDTH-1:0]    r_imm;

  logic                w_bubble;
  logic [WIDTH-1:0]    w_fwd_a;
  logic [WIDTH-1:0]    w_fwd_b;
  ctrl_t               w_id_ctrl;

  assign w_id_ctrl = '{reg_write:  id_reg_write,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       mem_to_reg: id_mem_to_reg};

  // A load in EX cannot forward its data until MEM, so any reader in ID waits.
  // Because this uses r_valid, an async reset drops it immediately.
  assign stall_req = r_valid && r_ctrl.mem_read && (r_dest != ZERO_REG) && id_valid &&
                     ((r_dest == id_rs) || (r_dest == id_rt));

  assign w_bubble = flush || stall_req || !id_valid;

  // Latch decoded fields; a bubble only needs valid and control cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_NONE;
      r_alu_ctrl <= ALU_ADD;
      r_alu_src  <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_dest     <= '0;
      r_data_a   <= '0;
      r_data_b   <= '0;
      r_imm      <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, matching flop behaviour.
      r_alu_ctrl <= alu_op_t'(id_alu_ctrl);
      r_alu_src  <= id_alu_src;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_dest     <= id_reg_dst ? id_rd : id_rt;
      r_data_a   <= id_data_a;
      r_data_b   <= id_data_b;
      r_imm      <= id_imm;
      if (w_bubble) begin
        r_valid <= 1'b0;
        r_ctrl  <= CTRL_NONE;
      end else begin
        r_valid <= 1'b1;
        r_ctrl  <= w_id_ctrl;
      end
    end
  end

  fwd_mux #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) u_fwd_a (
    .i_src             (r_rs),
    .i_data_q          (r_data_a),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_data      (memwb_data),
    .o_data            (w_fwd_a)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) u_fwd_b (
    .i_src             (r_rt),
    .i_data_q          (r_data_b),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_data      (memwb_data),
    .o_data            (w_fwd_b)
  );

  // Store data always takes the forwarded rt, even when B carries the immediate.
  assign BussA         = w_fwd_a;
  assign BussB         = r_alu_src ? r_imm : w_fwd_b;
  assign ex_store_data = w_fwd_b;
  assign ALUControl    = r_alu_ctrl;
  assign ex_dest       = r_dest;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;

endmodule
